// File: rtl/fetch_queue.sv
// Instruction fetch unit: owns the PC, issues word reads over req/ack, buffers results with their PCs.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [15:0]       br_imm16,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_dropped,
  output logic [31:0]       perf_stall
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e            state_r, state_n;
  logic [ADDR_W-1:0] fetch_pc_r, fetch_pc_n;
  logic              req_r, req_n;
  logic [ADDR_W-1:0] addr_r, addr_n;
  logic [CW-1:0]     count_r, count_n;
  logic [PW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [ADDR_W-1:0] pc_mem_r [DEPTH];

  logic              complete_s, pop_s, push_s, space_s, issue_s;
  logic [ADDR_W-1:0] imm_ext_s, target_s;

  // Handshake events, redirect target and post-edge occupancy
  always_comb begin
    imm_ext_s  = {{(ADDR_W-16){br_imm16[15]}}, br_imm16};
    target_s   = br_pc + ADDR_W'(32'd4) + (imm_ext_s << 2'd2);
    complete_s = req_r & imem_ack;
    pop_s      = (count_r != {CW{1'b0}}) & inst_ready;
    push_s     = (state_r == WAIT) & complete_s & ~br_taken;
    if (br_taken) begin
      count_n    = {CW{1'b0}};
      fetch_pc_n = target_s;
    end else begin
      count_n    = count_r + CW'(push_s) - CW'(pop_s);
      fetch_pc_n = push_s ? (fetch_pc_r + ADDR_W'(32'd4)) : fetch_pc_r;
    end
    // A slot is reserved for every outstanding read, so space is judged after this edge's push/pop
    space_s = (count_n < DEPTH_C);
  end

  // Next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (space_s) begin
          state_n = WAIT;
        end else begin
          state_n = IDLE;
        end
      end
      WAIT: begin
        if (!complete_s) begin
          state_n = br_taken ? DROP : WAIT;
        end else begin
          state_n = space_s ? WAIT : IDLE;
        end
      end
      DROP: begin
        if (!complete_s) begin
          state_n = DROP;
        end else begin
          state_n = space_s ? WAIT : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Request outputs: a new address is launched only when a fresh read starts
  always_comb begin
    issue_s = (state_n == WAIT) & ((state_r == IDLE) | complete_s);
    req_n   = (state_n != IDLE);
    if (issue_s) begin
      addr_n = {fetch_pc_n[ADDR_W-1:2], 2'b00};
    end else begin
      addr_n = addr_r;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // PC, request and queue bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= RESET_PC;
      req_r      <= 1'b0;
      addr_r     <= RESET_PC;
      count_r    <= {CW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
    end else begin
      fetch_pc_r <= fetch_pc_n;
      req_r      <= req_n;
      addr_r     <= addr_n;
      count_r    <= count_n;
      if (br_taken) begin
        wr_ptr_r <= {PW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
      end else begin
        wr_ptr_r <= wr_ptr_r + PW'(push_s);
        rd_ptr_r <= rd_ptr_r + PW'(pop_s);
      end
    end
  end

  // Queue storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_r[i] <= {DATA_W{1'b0}};
        pc_mem_r[i]   <= {ADDR_W{1'b0}};
      end
    end else if (push_s) begin
      data_mem_r[wr_ptr_r] <= imem_rdata;
      pc_mem_r[wr_ptr_r]   <= addr_r;
    end
  end

  assign imem_req   = req_r;
  assign imem_addr  = addr_r;
  assign inst_valid = (count_r != {CW{1'b0}});
  assign inst       = data_mem_r[rd_ptr_r];
  assign inst_pc    = pc_mem_r[rd_ptr_r];

`ifdef FETCH_PERF_CNT_EN
  // Performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= 32'd0;
      perf_dropped <= 32'd0;
      perf_stall   <= 32'd0;
    end else begin
      perf_fetched <= perf_fetched + {31'd0, push_s};
      perf_dropped <= perf_dropped + {31'd0, complete_s & (br_taken | (state_r == DROP))};
      perf_stall   <= perf_stall + {31'd0, ~inst_valid};
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic against a queue model.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_pc = 32'd0;
  logic [15:0] br_imm16 = 16'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_dropped, perf_stall;
`endif

  fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .br_taken(br_taken), .br_pc(br_pc), .br_imm16(br_imm16),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {instr, pc} and the single outstanding read
  logic [63:0] q[$];
  logic [31:0] m_fpc, m_addr;
  bit          m_out, m_drop, lat_rand;
  int          m_age, m_lat, lat_fix;
  int unsigned m_fetched, m_dropped, m_stall;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; br_taken = 1'b0; inst_ready = 1'b0; imem_ack = 1'b0;
    q.delete(); m_fpc = RESET_PC; m_addr = RESET_PC; m_out = 1'b0; m_drop = 1'b0;
    m_age = 0; m_lat = 1; lat_fix = 1; lat_rand = 1'b0;
    m_fetched = 0; m_dropped = 0; m_stall = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, return 1 time unit after it
  task automatic step(input bit br, input logic [31:0] bpc, input logic [15:0] bimm, input bit rdy);
    bit ack, pop;
    logic [31:0] tgt;
    ack = m_out && (m_age + 1 >= m_lat);
    br_taken = br; br_pc = bpc; br_imm16 = bimm; inst_ready = rdy;
    imem_ack = ack; imem_rdata = memf(imem_addr);
    pop = rdy && (q.size() != 0);
    if (q.size() == 0) m_stall++;
    if (br) begin
      tgt = bpc + 32'd4 + ({{16{bimm[15]}}, bimm} << 2);
      q.delete();
      m_fpc = tgt;
      if (m_out && !ack) begin
        m_drop = 1'b1;
      end else begin
        if (ack) m_dropped++;
        m_out = 1'b0; m_drop = 1'b0;
      end
    end else begin
      if (pop) void'(q.pop_front());
      if (ack) begin
        if (m_drop) m_dropped++;
        else begin
          q.push_back({memf(m_addr), m_addr});
          m_fpc = m_fpc + 32'd4;
          m_fetched++;
        end
        m_out = 1'b0; m_drop = 1'b0;
      end
    end
    if (m_out) m_age++;
    else if (q.size() < DEPTH) begin
      m_out = 1'b1; m_addr = m_fpc & ~32'd3; m_age = 0;
      m_lat = lat_rand ? 1 + int'($urandom % 4) : lat_fix;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL rst_addr got %h exp %h", imem_addr, RESET_PC); end
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 16'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
    checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL rst_addr2 got %h exp %h", imem_addr, RESET_PC); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", inst_valid); end
    checks++; if ({inst, inst_pc} !== 64'd0) begin errors++; $display("FAIL rst_head got %h/%h exp 0/0", inst, inst_pc); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_fetched !== 32'd0) begin errors++; $display("FAIL rst_perf got %0d exp 0", perf_fetched); end
`endif
  endtask

  task automatic test_stream(input int lat);
    bit rdy;
    do_reset();
    lat_fix = lat;
    for (int i = 0; i < 20; i++) begin
      rdy = (lat == 1) ? 1'b1 : 1'($urandom % 2);
      step(1'b0, 32'd0, 16'd0, rdy);
      if (lat == 1 && i < 3) begin
        checks++; if (imem_addr !== RESET_PC + 32'(4 * i)) begin errors++; $display("FAIL stream_addr%0d got %h exp %h", i, imem_addr, RESET_PC + 32'(4 * i)); end
      end
      if (lat == 1 && i >= 1 && i <= 3) begin
        checks++; if (inst_pc !== RESET_PC + 32'(4 * (i - 1))) begin errors++; $display("FAIL stream_pc%0d got %h exp %h", i, inst_pc, RESET_PC + 32'(4 * (i - 1))); end
      end
      checks++; if (imem_req !== m_out) begin errors++; $display("FAIL stream_req lat%0d cyc%0d got %b exp %b", lat, i, imem_req, m_out); end
      if (m_out) begin
        checks++; if (imem_addr !== m_addr) begin errors++; $display("FAIL stream_raddr lat%0d cyc%0d got %h exp %h", lat, i, imem_addr, m_addr); end
      end
      checks++; if (inst_valid !== (q.size() != 0)) begin errors++; $display("FAIL stream_valid lat%0d cyc%0d got %b exp %0d", lat, i, inst_valid, q.size()); end
      if (q.size() != 0) begin
        checks++; if ({inst, inst_pc} !== q[0]) begin errors++; $display("FAIL stream_head lat%0d cyc%0d got %h/%h exp %h", lat, i, inst, inst_pc, q[0]); end
      end
    end
  endtask

  task automatic test_full();
    int reads, issues;
    bit rq, prev;
    do_reset();
    reads = 0;
    for (int i = 0; i < 10; i++) begin
      rq = imem_req;
      step(1'b0, 32'd0, 16'd0, 1'b0);
      if (rq && imem_ack) reads++;
    end
    checks++; if (reads !== 4) begin errors++; $display("FAIL full_reads got %0d exp 4", reads); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL full_req got %b exp 0", imem_req); end
    checks++; if (inst_pc !== RESET_PC) begin errors++; $display("FAIL full_head got %h exp %h", inst_pc, RESET_PC); end
    issues = 0;
    for (int i = 0; i < 6; i++) begin
      prev = imem_req;
      step(1'b0, 32'd0, 16'd0, (i == 0));
      if (!prev && imem_req) issues++;
    end
    checks++; if (issues !== 1) begin errors++; $display("FAIL full_issue got %0d exp 1", issues); end
    checks++; if (inst_pc !== RESET_PC + 32'd4) begin errors++; $display("FAIL full_pop got %h exp %h", inst_pc, RESET_PC + 32'd4); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL full_req2 got %b exp 0", imem_req); end
  endtask

  task automatic test_redirect_outstanding();
    int n;
    do_reset();
    step(1'b0, 32'd0, 16'd0, 1'b0);
    step(1'b0, 32'd0, 16'd0, 1'b0);
    lat_fix = 3;
    step(1'b0, 32'd0, 16'd0, 1'b0);
    checks++; if (imem_addr !== 32'h108) begin errors++; $display("FAIL redir_pre got %h exp 108", imem_addr); end
    step(1'b1, 32'h104, 16'hFFFE, 1'b0);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %b exp 0", inst_valid); end
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h108}) begin errors++; $display("FAIL redir_hold got %b/%h exp 1/108", imem_req, imem_addr); end
    n = 0;
    while (imem_req && imem_addr == 32'h108 && n < 6) begin
      step(1'b0, 32'd0, 16'd0, 1'b0);
      n++;
    end
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin errors++; $display("FAIL redir_target got %b/%h exp 1/100", imem_req, imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_drop got %b exp 0", inst_valid); end
    n = 0;
    while (!inst_valid && n < 6) begin
      step(1'b0, 32'd0, 16'd0, 1'b0);
      n++;
    end
    checks++; if ({inst, inst_pc} !== {memf(32'h100), 32'h100}) begin errors++; $display("FAIL redir_head got %h/%h exp %h/100", inst, inst_pc, memf(32'h100)); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_dropped !== 32'd1) begin errors++; $display("FAIL redir_perf got %0d exp 1", perf_dropped); end
`endif
  endtask

  task automatic test_redirect_same_edge();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 16'd0, 1'b1);
    step(1'b1, 32'h200, 16'd3, 1'b1);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL same_flush got %b exp 0", inst_valid); end
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h210}) begin errors++; $display("FAIL same_target got %b/%h exp 1/210", imem_req, imem_addr); end
    step(1'b0, 32'd0, 16'd0, 1'b1);
    checks++; if ({inst_valid, inst, inst_pc} !== {1'b1, memf(32'h210), 32'h210}) begin errors++; $display("FAIL same_head got %b/%h/%h exp 1/%h/210", inst_valid, inst, inst_pc, memf(32'h210)); end
  endtask

  task automatic test_wrap();
    step(1'b1, 32'hFFFF_FFFC, 16'd0, 1'b1);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL wrap_target got %b/%h exp 1/0", imem_req, imem_addr); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_dropped !== 32'd2) begin errors++; $display("FAIL wrap_perf got %0d exp 2", perf_dropped); end
`endif
  endtask

  task automatic test_random();
    bit br;
    do_reset();
    lat_rand = 1'b1;
    for (int i = 0; i < 600; i++) begin
      br = ($urandom % 20) == 0;
      step(br, $urandom, 16'($urandom), ($urandom % 4) != 0);
      checks++; if (imem_req !== m_out) begin errors++; $display("FAIL rand_req cyc%0d got %b exp %b", i, imem_req, m_out); end
      if (m_out) begin
        checks++; if (imem_addr !== m_addr) begin errors++; $display("FAIL rand_addr cyc%0d got %h exp %h", i, imem_addr, m_addr); end
      end
      checks++; if (inst_valid !== (q.size() != 0)) begin errors++; $display("FAIL rand_valid cyc%0d got %b exp %0d", i, inst_valid, q.size()); end
      if (q.size() != 0) begin
        checks++; if ({inst, inst_pc} !== q[0]) begin errors++; $display("FAIL rand_head cyc%0d got %h/%h exp %h", i, inst, inst_pc, q[0]); end
      end
    end
`ifdef FETCH_PERF_CNT_EN
    checks++; if ({perf_fetched, perf_dropped, perf_stall} !== {m_fetched, m_dropped, m_stall}) begin
      errors++; $display("FAIL rand_perf got %0d/%0d/%0d exp %0d/%0d/%0d", perf_fetched, perf_dropped, perf_stall, m_fetched, m_dropped, m_stall);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stream(1);
    test_stream(3);
    test_full();
    test_redirect_outstanding();
    test_redirect_same_edge();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch unit, successor to the single-cycle PC/SRAM fetch path.
- Owns the PC and issues word reads to instruction memory over a req/ack handshake that tolerates variable latency.
- Buffers returned instructions, each with its PC, in a DEPTH-entry queue drained by decode over a valid/ready handshake.
- Accepts taken-branch redirects (PC-relative imm16), which flush the queue and discard any in-flight response.

Parameters:
ADDR_W, 32, PC/memory address width in bits
DATA_W, 32, instruction width in bits
DEPTH, 4, queue entries; power of two, 2..16
RESET_PC, 0, fetch address loaded at reset; word aligned

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
br_taken  in  1  redirect request, sampled at clock edge
br_pc  in  ADDR_W  PC of the taken branch
br_imm16  in  16  signed word offset of the branch
imem_req  out  1  memory read request; held high until acknowledged
imem_addr  out  ADDR_W  read address; stable while imem_req is high
imem_ack  in  1  read complete; imem_rdata valid this cycle
imem_rdata  in  DATA_W  returned instruction
inst_valid  out  1  queue head valid
inst  out  DATA_W  queue head instruction
inst_pc  out  ADDR_W  queue head PC
inst_ready  in  1  decode accepts the head

Behaviour:
- Reset (async, while rst_n=0):
  - fetch_pc=RESET_PC; queue empty (count=0, pointers 0); state IDLE.
  - imem_req=0; imem_addr=RESET_PC; inst_valid=0; inst=0; inst_pc=0.
- Registered outputs:
  - imem_req and imem_addr are registered.
  - inst/inst_pc come from the queue head; inst_valid = (count != 0).
- States:
  - IDLE: no outstanding read.
  - WAIT: read outstanding, data to be kept.
  - DROP: read outstanding, data to be discarded.
- Issue rule:
  - Issue when count + outstanding(0/1) < DEPTH.
  - IDLE with space -> imem_req=1, imem_addr=fetch_pc next cycle, enter WAIT.
- Completion:
  - A read completes at the rising edge where imem_req=1 and imem_ack=1.
  - In WAIT: push {imem_rdata, imem_addr} into the queue; fetch_pc += 4.
  - If space still remains, imem_req stays high with the new address (back-to-back; 1 instr/cycle with zero-wait memory). Otherwise go to IDLE with imem_req=0.
- Dequeue: at an edge with inst_valid=1 and inst_ready=1.
  - Simultaneous push and pop: count unchanged; FIFO order preserved.
- Full queue:
  - count=DEPTH -> no request is issued.
  - The reservation rule guarantees a completing read always has a free slot; no overflow is possible.
- Pointer wrap: pointers wrap modulo DEPTH.
- Redirect: at an edge with br_taken=1, redirect has priority over push and pop.
  - target = br_pc + 4 + (sign_extend(br_imm16) << 2), truncated to ADDR_W (wraps).
  - Queue flushed: count=0, inst_valid=0 next cycle.
  - fetch_pc=target.
  - If a read is outstanding and not completing this edge: go to DROP and keep imem_req/imem_addr unchanged until ack (a request is never abandoned). The ack'd data is discarded; then issue target next cycle.
  - If completing this edge: data discarded; next cycle request target.
  - br_taken while already in DROP: update fetch_pc to the new target; remain in DROP.
  - A pop at the redirect edge is still a completed transfer from decode's side; the flush then removes the rest.
- Alignment: fetch_pc[1:0] is forced to 0 for all address generation.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - Adds outputs perf_fetched (32 bits: reads pushed into the queue), perf_dropped (32 bits: reads discarded via DROP or same-edge redirect) and perf_stall (32 bits: cycles with inst_valid=0).
  - Counters reset to 0 and wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=0x100, zero-wait memory (ack=req), inst_ready=1 -> imem_addr 0x100, 0x104, 0x108 on consecutive cycles; inst_pc follows one cycle later.
- inst_ready=0, DEPTH=4 -> exactly 4 reads complete, imem_req drops, count=4. Ready=1 for one cycle -> one pop, exactly one new read issued.
- Memory with 3-cycle ack latency -> imem_addr stable and imem_req high for 3 cycles per read; queue order and PCs correct.
- Redirect while read to 0x108 is outstanding; br_pc=0x104, br_imm16=0xFFFE -> queue empty next cycle, 0x108 data dropped on ack, next request to 0x100.
- br_taken on the same edge as ack, br_pc=0x200, br_imm16=3 -> returned data not enqueued, next imem_addr=0x210.
- br_pc=0xFFFFFFFC, br_imm16=0 -> target wraps to 0x00000000. With FETCH_PERF_CNT_EN, perf_dropped increments by 1 per discarded read.
